// File: rtl/demux_pkg.sv
// Shared lane-count, select-width and buffer-state definitions for the 4-way registered demux.
package demux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  // One-hot lane decode of a select value.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_WIDTH-1:0] sel);
    return NUM_LANES'(1) << sel;
  endfunction

endpackage

// File: rtl/buf2_fifo.sv
// Generic 2-entry in-order FIFO; the head holds the last popped entry while empty.
module buf2_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             not_full,
  output logic             not_empty,
  output logic [WIDTH-1:0] head
);

  buf_state_t       state_q, state_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] last_q;
  logic             push_ok, pop_ok;

  // The unused encoding 2'd3 decodes as empty.
  assign not_empty = (state_q == ST_HALF) || (state_q == ST_FULL);
  assign not_full  = (state_q != ST_FULL);
  assign push_ok   = push && not_full;
  assign pop_ok    = pop && not_empty;
  assign head      = not_empty ? mem_q[rd_ptr_q] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALF: begin
        if (push_ok && !pop_ok)      state_d = ST_FULL;
        else if (pop_ok && !push_ok) state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop_ok) state_d = ST_HALF;
      end
      default: begin
        if (push_ok) state_d = ST_HALF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      last_q   <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/demux_buf_4.sv
// 4-way registered demultiplexer: buffers {sel, data} beats and delivers each to one lane in order.
module demux_buf_4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WIDTH-1:0]                 Data_in,
  input  logic [SEL_WIDTH-1:0]             select,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH-1:0]                 Data_out,
  output logic [NUM_LANES-1:0]             out_valid,
  input  logic [NUM_LANES-1:0]             out_ready,
  output logic [NUM_LANES*COUNT_WIDTH-1:0] lane_count
);

  localparam int unsigned ENTRY_WIDTH = WIDTH + SEL_WIDTH;

  logic                   push, pop;
  logic                   not_full, not_empty;
  logic [ENTRY_WIDTH-1:0] head;
  logic [SEL_WIDTH-1:0]   head_sel;

  // Ready depends only on registered occupancy, gated low while reset is held.
  assign in_ready  = rst_n && not_full;
  assign push      = in_valid && in_ready;
  assign head_sel  = head[WIDTH +: SEL_WIDTH];
  assign Data_out  = head[WIDTH-1:0];
  assign out_valid = not_empty ? lane_onehot(head_sel) : '0;
  assign pop       = not_empty && out_ready[head_sel];

  buf2_fifo #(
    .WIDTH(ENTRY_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({select, Data_in}),
    .pop      (pop),
    .not_full (not_full),
    .not_empty(not_empty),
    .head     (head)
  );

  // Per-lane delivered-beat counters, wrapping silently.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_cnt
    logic [COUNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (pop && (head_sel == SEL_WIDTH'(k))) begin
        cnt_q <= cnt_q + COUNT_WIDTH'(1);
      end
    end

    assign lane_count[k*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
  end

endmodule
